uart_wb_master: RTL and testbench
=================================

Name: uart_wb_master

Overview:
Wishbone initiator that drives the UART register slave from a simple command/response port, e.g. for a host bridge or self-test sequencer.
Accepts one command at a time and runs one classic single Wishbone cycle (CYC/STB held until ACK).
Handles byte-lane steering for 8-bit accesses and full-word 32-bit accesses, and returns a response with read data or an error flag.
A cycle counter aborts transfers that are never acknowledged.

Parameters:
ADDR_WIDTH, 5, width of wb_adr_o and cmd_adr_i (matches UART_ADDR_WIDTH)
TIMEOUT, 16, cycles with CYC/STB asserted before the transfer is aborted; legal range 2..255

Ports:
clk  in  1  system clock
wb_rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_we_i  in  1  1 = write, 0 = read
cmd_size_i  in  1  0 = byte access, 1 = 32-bit word access
cmd_adr_i  in  ADDR_WIDTH  byte address
cmd_dat_i  in  32  write data; byte access uses bits [7:0]
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
rsp_dat_o  out  32  read data; byte read is zero-extended into [7:0]
rsp_err_o  out  1  1 = timeout or misaligned access
wb_cyc_o  out  1  Wishbone CYC
wb_stb_o  out  1  Wishbone STB
wb_we_o  out  1  Wishbone WE
wb_adr_o  out  ADDR_WIDTH  Wishbone address
wb_sel_o  out  4  Wishbone byte selects
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone ACK
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; every output 0 except cmd_ready_o = 1; timeout counter 0. Assertion mid-transfer drops CYC/STB immediately (asynchronous) and discards any pending response.
- All outputs are registered, except cmd_ready_o and busy_o, which are decoded from the state register.
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On accept at edge N, latch the command.
  - Misaligned word access (cmd_size_i = 1 and cmd_adr_i[1:0] != 0): go straight to RESP with rsp_err_o = 1 and rsp_dat_o = 0. No bus cycle is run.
  - Otherwise go to BUS. wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o are valid from edge N and held stable throughout BUS.
- Byte steering:
  - Byte access: wb_sel_o = 4'b0001 << adr[1:0]; the write byte is placed in the matching lane and the other lanes are 0; read data = selected lane of wb_dat_i.
  - Word access: wb_sel_o = 4'b1111; wb_dat_o = cmd_dat_i; read data = wb_dat_i.
- BUS:
  - Counter increments each cycle.
  - On wb_ack_i = 1: capture read data (0 for writes), set rsp_err_o = 0, deassert CYC/STB at that same edge, go to RESP.
  - If the counter reaches TIMEOUT - 1 with no ACK: deassert CYC/STB, rsp_dat_o = 0, rsp_err_o = 1, go to RESP.
  - ACK on the timeout cycle counts as success.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o held stable.
  - On rsp_ready_i: clear rsp_valid_o and return to IDLE. The next command can be accepted the cycle after.
  - Minimum spacing between bus cycles is therefore 2 idle clocks, which covers the slave's ACK recovery.
- wb_ack_i outside BUS is ignored. No pipelining, no burst, and no more than one outstanding transfer.
- Every command, including writes, produces exactly one response.

Test Plan:
1. Byte write: adr 0x03, dat 0x000000A5 -> wb_sel_o = 1000, wb_dat_o = 0xA5000000, wb_we_o = 1. Slave ACKs 2 cycles later -> CYC/STB low at the ACK edge; rsp_valid_o with err = 0, dat = 0.
2. Byte read: adr 0x01, slave returns 0x11223344 -> wb_sel_o = 0010, rsp_dat_o = 0x00000033, err = 0.
3. Word read: adr 0x04, size = 1, slave returns 0xDEADBEEF -> wb_sel_o = 1111, rsp_dat_o = 0xDEADBEEF.
4. Misaligned word access at adr 0x06 -> no CYC ever asserted; response with err = 1 on the cycle after accept.
5. No ACK, TIMEOUT = 16 -> CYC/STB high for exactly 16 cycles, then response with err = 1, dat = 0. Repeat with ACK on cycle 16 -> err = 0.
6. Reset asserted during BUS -> CYC/STB/rsp_valid_o go to 0 without waiting for a clock edge. After release, cmd_ready_o = 1 and a new read completes normally. Also hold rsp_ready_i low for 5 cycles -> response held stable and cmd_ready_o = 0 throughout.

Source files
------------

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - single-transfer Wishbone initiator for the UART register slave
module uart_wb_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic                  cmd_size_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        size_q;
  logic [1:0]  lane_q;
  logic        misaligned;
  logic [3:0]  sel_d;
  logic [31:0] wdat_d;
  logic [31:0] rdat;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign misaligned  = cmd_size_i && (cmd_adr_i[1:0] != 2'b00);

  // Byte accesses ride on the lane picked by the low address bits.
  always_comb begin
    sel_d  = 4'b1111;
    wdat_d = cmd_dat_i;
    if (!cmd_size_i) begin
      sel_d  = 4'b0001 << cmd_adr_i[1:0];
      wdat_d = {24'd0, cmd_dat_i[7:0]} << {cmd_adr_i[1:0], 3'b000};
    end
  end

  always_comb begin
    rdat = wb_dat_i;
    if (!size_q) rdat = {24'd0, wb_dat_i[8*lane_q +: 8]};
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= 1'b0;
      lane_q      <= 2'b00;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            size_q <= cmd_size_i;
            lane_q <= cmd_adr_i[1:0];
            cnt    <= '0;
            if (misaligned) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_dat_o   <= '0;
              state       <= RESP;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= cmd_we_i;
              wb_adr_o <= cmd_adr_i;
              wb_sel_o <= sel_d;
              wb_dat_o <= wdat_d;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          // ACK wins over the timeout when both land on the same edge.
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= wb_we_o ? 32'd0 : rdat;
            state       <= RESP;
          end else if (cnt == LAST_CNT) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_dat_o   <= '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb/tb_uart_wb_master.sv - scoreboard bench for uart_wb_master with a behavioural slave
module tb_uart_wb_master;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic          cmd_size_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [31:0]   cmd_dat_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_dat_o;
  logic          rsp_err_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          busy_o;

  uart_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dat; logic err; int len; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] adr; logic [3:0] sel; logic [31:0] dat; } bus_t;

  rsp_t        exp_q[$];
  bus_t        bus_q[$];
  int          tests = 0;
  int          fails = 0;
  int          slave_ack_at = 0;
  logic [31:0] slave_data = '0;
  int          cur_len = 0;
  int          last_len = 0;
  bus_t        cur_bus;
  bit          stab_bad = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] hold_dat;
  logic        hold_err;
  rsp_t        got_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Slave model plus bus monitor: ACKs on the slave_ack_at-th CYC cycle (0 = never).
  always @(negedge clk) begin
    if (wb_cyc_o || wb_stb_o) begin
      if (cur_len == 0) begin
        stab_bad = 1'b0;
        if (bus_q.size() == 0) begin
          check("bus_unexpected_cycle", wb_cyc_o, 1'b0);
        end else begin
          cur_bus = bus_q.pop_front();
          check("bus_we", wb_we_o, cur_bus.we);
          check("bus_adr", wb_adr_o, cur_bus.adr);
          check("bus_sel", wb_sel_o, cur_bus.sel);
          check("bus_wdat", wb_dat_o, cur_bus.dat);
          check("bus_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
        end
      end else if (wb_we_o !== cur_bus.we || wb_adr_o !== cur_bus.adr || wb_sel_o !== cur_bus.sel ||
                   wb_dat_o !== cur_bus.dat || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
        stab_bad = 1'b1;
      end
      cur_len++;
      wb_ack_i = (cur_len == slave_ack_at);
      wb_dat_i = wb_ack_i ? slave_data : $urandom;
    end else begin
      if (cur_len != 0) begin
        check("bus_stable", stab_bad, 1'b0);
        last_len = cur_len;
        cur_len = 0;
      end
      if (cmd_valid_i && cmd_ready_o && !wb_rst_i) last_len = 0;
      wb_ack_i = ($urandom_range(3) == 0);
      wb_dat_i = $urandom;
    end
  end

  // Response monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (wb_rst_i) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("rsp_hold_valid", rsp_valid_o, 1'b1);
        check("rsp_hold_dat", rsp_dat_o, hold_dat);
        check("rsp_hold_err", rsp_err_o, hold_err);
      end
      if (rsp_valid_o) begin
        check("resp_ready_busy", {cmd_ready_o, busy_o}, 2'b01);
        if (rsp_ready_i) begin
          prev_hold = 1'b0;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid_o, 1'b0);
          end else begin
            got_e = exp_q.pop_front();
            check("rsp_dat", rsp_dat_o, got_e.dat);
            check("rsp_err", rsp_err_o, got_e.err);
            check("cyc_length", last_len, got_e.len);
          end
        end else begin
          prev_hold = 1'b1;
          hold_dat  = rsp_dat_o;
          hold_err  = rsp_err_o;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // Reference model: decides the expected bus fields and response from the command alone.
  function automatic bit expect_cmd(input logic we, input logic size, input logic [AW-1:0] adr,
                                    input logic [31:0] d, input int ack_at, input logic [31:0] sd);
    rsp_t e;
    bus_t b;
    int   lane;
    bit   mis;
    bit   ok;
    lane = int'(adr[1:0]);
    mis  = size && (lane != 0);
    ok   = (ack_at >= 1) && (ack_at <= TO);
    if (mis) begin
      e.err = 1'b1; e.dat = '0; e.len = 0;
    end else begin
      e.err = !ok;
      e.len = ok ? ack_at : TO;
      if (!ok || we) e.dat = '0;
      else if (size) e.dat = sd;
      else e.dat = (sd >> (8 * lane)) & 32'hFF;
      b.we  = we;
      b.adr = adr;
      b.sel = size ? 4'hF : 4'(1 << lane);
      b.dat = size ? d : ((d & 32'hFF) << (8 * lane));
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
    return mis;
  endfunction

  task automatic send_cmd(input logic we, input logic size, input logic [AW-1:0] adr, input logic [31:0] d);
    int n;
    n = 0;
    cmd_we_i = we; cmd_size_i = size; cmd_adr_i = adr; cmd_dat_i = d; cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'($urandom); cmd_size_i = 1'($urandom);
    cmd_adr_i = AW'($urandom); cmd_dat_i = $urandom;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid_o && n < TO + 8) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrives", rsp_valid_o, 1'b1);
  endtask

  task automatic do_cmd(input logic we, input logic size, input logic [AW-1:0] adr, input logic [31:0] d,
                        input int ack_at, input logic [31:0] sd, input int hold);
    bit mis;
    mis = expect_cmd(we, size, adr, d, ack_at, sd);
    slave_ack_at = ack_at;
    slave_data   = sd;
    send_cmd(we, size, adr, d);
    @(negedge clk);
    check("first_cycle_cyc", wb_cyc_o, !mis);
    check("first_cycle_rsp_valid", rsp_valid_o, mis);
    wait_rsp();
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
  endtask

  // Asserts reset between clock edges and checks the outputs fall with no edge.
  task automatic reset_mid();
    #2 wb_rst_i = 1'b1;
    #1;
    check("rst_async_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    check("rst_async_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_async_ready_busy", {cmd_ready_o, busy_o}, 2'b10);
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 wb_rst_i = 1'b0;
  endtask

  initial begin
    bit dummy;
    #12;
    check("reset_ready_busy", {cmd_ready_o, busy_o}, 2'b10);
    check("reset_wb_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 7'd0);
    check("reset_wb_adr_dat", {27'd0, wb_adr_o} | wb_dat_o, 32'd0);
    check("reset_rsp", {rsp_valid_o, rsp_err_o}, 2'b00);
    check("reset_rsp_dat", rsp_dat_o, 32'd0);
    @(posedge clk);
    #1 wb_rst_i = 1'b0;

    do_cmd(1'b1, 1'b0, 5'h03, 32'h000000A5, 2, 32'h0, 0);
    do_cmd(1'b0, 1'b0, 5'h01, 32'h0, 3, 32'h11223344, 0);
    do_cmd(1'b0, 1'b1, 5'h04, 32'h0, 1, 32'hDEADBEEF, 1);
    do_cmd(1'b1, 1'b1, 5'h06, 32'h12345678, 1, 32'h0, 0);
    do_cmd(1'b0, 1'b1, 5'h08, 32'h0, 0, 32'h55AA55AA, 0);
    do_cmd(1'b0, 1'b1, 5'h08, 32'h0, TO, 32'hCAFEF00D, 0);

    dummy = expect_cmd(1'b0, 1'b1, 5'h0C, 32'h0, 0, 32'h0);
    slave_ack_at = 0;
    send_cmd(1'b0, 1'b1, 5'h0C, 32'h0);
    repeat (3) @(negedge clk);
    check("cyc_before_reset", wb_cyc_o, 1'b1);
    reset_mid();
    do_cmd(1'b0, 1'b0, 5'h02, 32'h0, 2, 32'h9988_7766, 5);

    dummy = expect_cmd(1'b0, 1'b0, 5'h00, 32'h0, 2, 32'h0000_00F0);
    slave_ack_at = 2;
    slave_data   = 32'h0000_00F0;
    send_cmd(1'b0, 1'b0, 5'h00, 32'h0);
    wait_rsp();
    @(negedge clk);
    reset_mid();
    do_cmd(1'b1, 1'b1, 5'h10, 32'hA1B2C3D4, 3, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      int r;
      int aa;
      r = $urandom_range(7);
      case (r)
        0:       aa = 0;
        1:       aa = TO;
        2:       aa = TO + 1;
        default: aa = $urandom_range(4, 1);
      endcase
      do_cmd(1'($urandom), 1'($urandom), AW'($urandom), $urandom, aa, $urandom, $urandom_range(3));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
